// File: rtl/pdm_transmitter.sv
// pdm_transmitter
//
// Playback-side PDM modulator. Accepts 8-bit signed audio samples through a
// valid/ready handshake and buffers them in a small FIFO. A first-order
// sigma-delta modulator turns the current sample into a 1-bit PDM stream.
// The sample is advanced once per window of SAMPLE_STEPS PDM bits.
//
// Parameters
//   STEP_PERIOD   clock cycles per PDM bit (>= 2)
//   SAMPLE_STEPS  PDM bits per audio sample (>= 2)
//   FIFO_DEPTH    sample FIFO entries (power of two, >= 2)
//
// Ports
//   clk_in           system clock
//   rst_in           asynchronous active-low reset
//   en_in            modulator enable; low holds step/sample counters and
//                    accumulator at 0 and forces the PDM outputs to 0
//   audio_in         signed 8-bit sample
//   audio_valid_in   sample offered this cycle
//   audio_ready_out  FIFO can accept a sample (decoded from registered count)
//   flags_clr_in     synchronous clear of the sticky flags (set wins)
//   pdm_out          registered PDM bit
//   pdm_step_out     one-cycle pulse in the cycle pdm_out takes a new value
//   fifo_count_out   current FIFO occupancy
//   underrun_out     sticky: a sample boundary found the FIFO empty
//   overflow_out     sticky: a sample was offered while the FIFO was full
//
// Build option
//   PDM_TX_UNDERRUN_MUTE_EN  when defined, an underrun boundary loads the
//                            mid-scale sample 8'sh00; otherwise the last
//                            sample is held.

module pdm_transmitter #(
  parameter int STEP_PERIOD  = 32,
  parameter int SAMPLE_STEPS = 256,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          en_in,
  input  logic [7:0]                    audio_in,
  input  logic                          audio_valid_in,
  output logic                          audio_ready_out,
  input  logic                          flags_clr_in,
  output logic                          pdm_out,
  output logic                          pdm_step_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic                          underrun_out,
  output logic                          overflow_out
);

  localparam int SC_W = $clog2(STEP_PERIOD);
  localparam int WC_W = $clog2(SAMPLE_STEPS);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;

  localparam logic [SC_W-1:0] SC_LAST = SC_W'(STEP_PERIOD - 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(SAMPLE_STEPS - 1);
  localparam logic [CW-1:0]   CNT_FULL = CW'(FIFO_DEPTH);

  // Step and sample counters
  logic [SC_W-1:0] sc;
  logic [WC_W-1:0] wc;
  logic            step;
  logic            boundary;

  // FIFO storage and bookkeeping
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  // Modulator state
  logic [7:0]      cur;
  logic [7:0]      acc;
  logic [7:0]      u;
  logic [8:0]      s;

  logic            underrun_ev;
  logic            overflow_ev;

  always_comb begin
    step            = en_in && (sc == SC_LAST);
    boundary        = step && (wc == WC_LAST);
    fifo_empty      = (count == '0);
    audio_ready_out = (count != CNT_FULL);
    push            = audio_valid_in && audio_ready_out;
    // A pop looks only at the registered count, so a sample pushed on the
    // boundary cycle into an empty FIFO waits for the next boundary.
    pop             = boundary && !fifo_empty;
    underrun_ev     = boundary && fifo_empty;
    overflow_ev     = audio_valid_in && !audio_ready_out;
    // Offset-binary view of the signed sample: 0..255, mid-scale at 128.
    u               = {~cur[7], cur[6:0]};
    s               = {1'b0, acc} + {1'b0, u};
    fifo_count_out  = count;
  end

  // Step counter: free-running while enabled, held at 0 otherwise.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sc <= '0;
    end else if (!en_in) begin
      sc <= '0;
    end else if (sc == SC_LAST) begin
      sc <= '0;
    end else begin
      sc <= sc + SC_W'(1);
    end
  end

  // Sample counter: advances once per step.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wc <= '0;
    end else if (!en_in) begin
      wc <= '0;
    end else if (step) begin
      if (wc == WC_LAST) begin
        wc <= '0;
      end else begin
        wc <= wc + WC_W'(1);
      end
    end
  end

  // FIFO storage needs no reset; validity is tracked by the pointers/count.
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr] <= audio_in;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Current sample register; the boundary step itself still uses the old
  // value because the modulator reads cur before this update lands.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cur <= '0;
    end else if (boundary) begin
      if (!fifo_empty) begin
        cur <= mem[rd_ptr];
      end else begin
`ifdef PDM_TX_UNDERRUN_MUTE_EN
        cur <= '0;
`else
        cur <= cur;
`endif
      end
    end
  end

  // First-order sigma-delta: the carry out of acc + u is the PDM bit.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      acc          <= '0;
      pdm_out      <= 1'b0;
      pdm_step_out <= 1'b0;
    end else if (!en_in) begin
      acc          <= '0;
      pdm_out      <= 1'b0;
      pdm_step_out <= 1'b0;
    end else begin
      pdm_step_out <= step;
      if (step) begin
        pdm_out <= s[8];
        acc     <= s[7:0];
      end
    end
  end

  // Sticky flags: a set event in the same cycle beats the clear.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      underrun_out <= 1'b0;
      overflow_out <= 1'b0;
    end else begin
      if (underrun_ev) begin
        underrun_out <= 1'b1;
      end else if (flags_clr_in) begin
        underrun_out <= 1'b0;
      end
      if (overflow_ev) begin
        overflow_out <= 1'b1;
      end else if (flags_clr_in) begin
        overflow_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pdm_transmitter.sv
`timescale 1ns/1ps
module tb_pdm_transmitter;

  // Short bit period keeps each 256-bit window at 1024 cycles.
  localparam int SP    = 4;
  localparam int SS    = 256;
  localparam int DEPTH = 4;
  localparam int W     = SP * SS;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [7:0]    audio;
  logic          audio_valid;
  logic          audio_ready;
  logic          flags_clr;
  logic          pdm;
  logic          pdm_step;
  logic [CW-1:0] fifo_count;
  logic          underrun;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int trk_mis  = 0;

  pdm_transmitter #(.STEP_PERIOD(SP), .SAMPLE_STEPS(SS), .FIFO_DEPTH(DEPTH)) dut (
    .clk_in          (clk),
    .rst_in          (rst_n),
    .en_in           (en),
    .audio_in        (audio),
    .audio_valid_in  (audio_valid),
    .audio_ready_out (audio_ready),
    .flags_clr_in    (flags_clr),
    .pdm_out         (pdm),
    .pdm_step_out    (pdm_step),
    .fifo_count_out  (fifo_count),
    .underrun_out    (underrun),
    .overflow_out    (overflow)
  );

  always #5 clk = ~clk;

  // Reference model: time index since enable, a queue for the FIFO and
  // plain integer arithmetic for the modulator.
  byte m_q[$];
  byte m_cur;
  int  m_acc;
  int  m_t;
  bit  m_pdm, m_step, m_under, m_over, m_bnd, m_pop;

  function automatic int uval(input logic [7:0] smp);
    return int'($signed(smp)) + 128;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_cur = 0; m_acc = 0; m_t = 0;
    m_pdm = 0; m_step = 0; m_under = 0; m_over = 0; m_bnd = 0; m_pop = 0;
  endtask

  // Advance the model over the coming rising edge, pass that edge, and
  // record any divergence of the DUT outputs from the model.
  task automatic cycle();
    int pre, sum;
    bit rdy, stp, bnd;
    if (!rst_n) begin
      model_reset();
    end else begin
      pre = m_q.size();
      rdy = (pre != DEPTH);
      stp = 0;
      bnd = 0;
      if (en) begin
        stp = ((m_t % SP) == SP - 1);
        bnd = stp && (((m_t / SP) % SS) == SS - 1);
        m_t++;
        if (stp) begin
          sum   = m_acc + int'(m_cur) + 128;
          m_pdm = (sum >= 256);
          m_acc = sum % 256;
        end
        m_step = stp;
      end else begin
        m_t = 0; m_acc = 0; m_pdm = 0; m_step = 0;
      end
      m_bnd = bnd;
      m_pop = 0;
      if (bnd) begin
        if (pre > 0) begin
          m_cur = m_q.pop_front();
          m_pop = 1;
        end else begin
`ifdef PDM_TX_UNDERRUN_MUTE_EN
          m_cur = 0;
`endif
        end
      end
      if (audio_valid && rdy) m_q.push_back(byte'(audio));
      if (bnd && pre == 0) m_under = 1; else if (flags_clr) m_under = 0;
      if (audio_valid && !rdy) m_over = 1; else if (flags_clr) m_over = 0;
    end
    @(negedge clk);
    if (pdm !== m_pdm || pdm_step !== m_step || fifo_count !== CW'(m_q.size()) ||
        audio_ready !== (m_q.size() != DEPTH) || underrun !== m_under || overflow !== m_over)
      trk_mis++;
  endtask

  task automatic push(input logic [7:0] smp);
    audio = smp; audio_valid = 1'b1;
    cycle();
    audio_valid = 1'b0;
  endtask

  task automatic clear_flags();
    flags_clr = 1'b1;
    cycle();
    flags_clr = 1'b0;
  endtask

  task automatic wait_pop(output bit ok);
    int guard = 0;
    ok = 0;
    while (!ok && guard < W + 4 * SP) begin
      cycle(); guard++;
      if (m_pop) ok = 1;
    end
  endtask

  task automatic count_window(output int ones, output bit ok);
    int steps = 0;
    int guard = 0;
    ones = 0;
    while (steps < SS && guard < W + 4 * SP) begin
      cycle(); guard++;
      if (m_step) begin
        steps++;
        if (pdm === 1'b1) ones++;
      end
    end
    ok = (steps == SS);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; audio = '0; audio_valid = 1'b0; flags_clr = 1'b0;
    repeat (3) cycle();
    n_checks++; if (pdm !== 1'b0) begin n_fail++; $display("FAIL reset_pdm: got %b expected 0", pdm); end
    n_checks++; if (pdm_step !== 1'b0) begin n_fail++; $display("FAIL reset_step: got %b expected 0", pdm_step); end
    n_checks++; if (fifo_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    n_checks++; if (audio_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", audio_ready); end
    n_checks++; if ({underrun, overflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b%b expected 00", underrun, overflow); end
    rst_n = 1'b1;
    repeat (2) cycle();
  endtask

  task automatic test_idle();
    int mis0 = trk_mis;
    int first_under = -1;
    int nst = 0;
    int bad = 0;
    logic [3:0] pat = '0;
    en = 1'b1;
    for (int i = 0; i < W + 4 * SP; i++) begin
      cycle();
      if (underrun === 1'b1 && first_under < 0) first_under = i;
      if (m_step && nst < 4) begin pat[nst] = pdm; nst++; end
      if (audio_ready !== 1'b1 || fifo_count !== '0) bad++;
    end
    n_checks++; if (pat !== 4'b1010) begin n_fail++; $display("FAIL idle_pattern: got %b expected 1010 (bit0 first)", pat); end
    n_checks++; if (first_under !== W - 1) begin n_fail++; $display("FAIL idle_first_boundary: got %0d expected %0d", first_under, W - 1); end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL idle_ready_count: got %0d bad cycles expected 0", bad); end
    n_checks++; if (trk_mis !== mis0) begin n_fail++; $display("FAIL idle_track: got %0d diffs expected 0", trk_mis - mis0); end
  endtask

  task automatic test_full_scale();
    int mis0 = trk_mis;
    int ones;
    bit ok, ok2;
    clear_flags();
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL flags_clear: got %b expected 0", underrun); end
    push(8'h7F);
    n_checks++; if (fifo_count !== CW'(1)) begin n_fail++; $display("FAIL push_count: got %0d expected 1", fifo_count); end
    wait_pop(ok); count_window(ones, ok2);
    n_checks++; if (!(ok && ok2) || ones !== 255) begin n_fail++; $display("FAIL full_pos: got %0d ones expected 255 (ok=%0d)", ones, ok && ok2); end
    push(8'h80);
    wait_pop(ok); count_window(ones, ok2);
    n_checks++; if (!(ok && ok2) || ones !== 0) begin n_fail++; $display("FAIL full_neg: got %0d ones expected 0 (ok=%0d)", ones, ok && ok2); end
    n_checks++; if (trk_mis !== mis0) begin n_fail++; $display("FAIL full_track: got %0d diffs expected 0", trk_mis - mis0); end
  endtask

  task automatic test_overflow();
    int mis0 = trk_mis;
    logic [7:0] smp [4];
    logic [7:0] extra;
    int r = int'($urandom_range(0, 255));
    int ones, exp_last;
    bit ok, ok2;
    clear_flags();
    for (int k = 0; k < 4; k++) smp[k] = 8'((r + k * 64) % 256);
    extra = smp[3] ^ 8'h55;
    for (int k = 0; k < 4; k++) push(smp[k]);
    n_checks++; if (fifo_count !== CW'(4)) begin n_fail++; $display("FAIL ovf_count: got %0d expected 4", fifo_count); end
    n_checks++; if (audio_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready: got %b expected 0", audio_ready); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", overflow); end
    push(extra);
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    n_checks++; if (fifo_count !== CW'(4)) begin n_fail++; $display("FAIL ovf_drop: got %0d expected 4", fifo_count); end
    wait_pop(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL ovf_pop_timeout: got no pop expected pop"); end
    for (int k = 0; k < 4; k++) begin
      count_window(ones, ok2);
      n_checks++; if (!ok2 || ones !== uval(smp[k])) begin n_fail++; $display("FAIL ovf_order%0d: got %0d ones expected %0d", k, ones, uval(smp[k])); end
    end
    n_checks++; if (fifo_count !== '0) begin n_fail++; $display("FAIL ovf_drain: got %0d expected 0", fifo_count); end
`ifdef PDM_TX_UNDERRUN_MUTE_EN
    exp_last = 128;
`else
    exp_last = uval(smp[3]);
`endif
    count_window(ones, ok2);
    n_checks++; if (!ok2 || ones !== exp_last) begin n_fail++; $display("FAIL ovf_after: got %0d ones expected %0d", ones, exp_last); end
    n_checks++; if (trk_mis !== mis0) begin n_fail++; $display("FAIL ovf_track: got %0d diffs expected 0", trk_mis - mis0); end
  endtask

  task automatic test_same_cycle();
    int mis0 = trk_mis;
    int guard = 0;
    int ones;
    bit ok, ok2;
    logic [7:0] smp = 8'($urandom_range(0, 255));
    clear_flags();
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL sc_clear: got %b expected 0", underrun); end
    while ((m_t % W) != W - 1 && guard < W + 2) begin cycle(); guard++; end
    push(smp);
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL sc_underrun: got %b expected 1", underrun); end
    n_checks++; if (fifo_count !== CW'(1)) begin n_fail++; $display("FAIL sc_kept: got %0d expected 1", fifo_count); end
    wait_pop(ok);
    n_checks++; if (!ok || fifo_count !== '0) begin n_fail++; $display("FAIL sc_pop: got count %0d expected 0 (ok=%0d)", fifo_count, ok); end
    count_window(ones, ok2);
    n_checks++; if (!ok2 || ones !== uval(smp)) begin n_fail++; $display("FAIL sc_window: got %0d ones expected %0d", ones, uval(smp)); end
    n_checks++; if (trk_mis !== mis0) begin n_fail++; $display("FAIL sc_track: got %0d diffs expected 0", trk_mis - mis0); end
  endtask

  task automatic test_underrun_build();
    int mis0 = trk_mis;
    int ones, exp_next;
    bit ok, ok2;
    push(8'h40);
    wait_pop(ok); count_window(ones, ok2);
    n_checks++; if (!(ok && ok2) || ones !== 192) begin n_fail++; $display("FAIL ur_play: got %0d ones expected 192", ones); end
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL ur_flag: got %b expected 1", underrun); end
`ifdef PDM_TX_UNDERRUN_MUTE_EN
    exp_next = 128;
`else
    exp_next = 192;
`endif
    count_window(ones, ok2);
    n_checks++; if (!ok2 || ones !== exp_next) begin n_fail++; $display("FAIL ur_next: got %0d ones expected %0d", ones, exp_next); end
    n_checks++; if (trk_mis !== mis0) begin n_fail++; $display("FAIL ur_track: got %0d diffs expected 0", trk_mis - mis0); end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    push(8'($urandom_range(0, 255)));
    push(8'($urandom_range(0, 255)));
    while (!m_pdm && guard < 64) begin cycle(); guard++; end
    n_checks++; if (fifo_count !== CW'(2) || underrun !== 1'b1) begin n_fail++; $display("FAIL rm_pre: got count %0d ur %b expected 2 1", fifo_count, underrun); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (pdm !== 1'b0 || pdm_step !== 1'b0) begin n_fail++; $display("FAIL rm_pdm: got %b%b expected 00", pdm, pdm_step); end
    n_checks++; if (fifo_count !== '0 || audio_ready !== 1'b1) begin n_fail++; $display("FAIL rm_fifo: got count %0d ready %b expected 0 1", fifo_count, audio_ready); end
    n_checks++; if ({underrun, overflow} !== 2'b00) begin n_fail++; $display("FAIL rm_flags: got %b%b expected 00", underrun, overflow); end
    model_reset();
    @(negedge clk);
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_enable();
    int mis0 = trk_mis;
    int pop_at = -1;
    int ones;
    bit ok2;
    logic [7:0] smp = 8'($urandom_range(0, 255));
    en = 1'b0;
    push(smp);
    repeat (40) cycle();
    n_checks++; if (fifo_count !== CW'(1) || pdm !== 1'b0) begin n_fail++; $display("FAIL en_low: got count %0d pdm %b expected 1 0", fifo_count, pdm); end
    en = 1'b1;
    for (int i = 0; i < W + 4 * SP && pop_at < 0; i++) begin
      cycle();
      if (m_pop) pop_at = i;
    end
    n_checks++; if (pop_at !== W - 1) begin n_fail++; $display("FAIL en_first_boundary: got %0d expected %0d", pop_at, W - 1); end
    count_window(ones, ok2);
    n_checks++; if (!ok2 || ones !== uval(smp)) begin n_fail++; $display("FAIL en_window: got %0d ones expected %0d", ones, uval(smp)); end
    n_checks++; if (trk_mis !== mis0) begin n_fail++; $display("FAIL en_track: got %0d diffs expected 0", trk_mis - mis0); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_full_scale();
    test_overflow();
    test_same_cycle();
    test_underrun_build();
    test_reset_mid();
    test_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pdm_transmitter.md
# pdm_transmitter

Playback-side counterpart of the microphone PDM decimator. It accepts 8-bit signed audio samples at the ~12 kHz sample rate through a valid/ready handshake and buffers them in a small FIFO. A first-order sigma-delta modulator turns each sample into a 1-bit PDM stream for the speaker/audio output. It runs on the 98.3 MHz `clk_m` domain, and its PDM bit rate and samples-per-window match the receive path: 3.072 MHz and 256 PDM bits per sample.

## Interface
Parameters:
- `STEP_PERIOD`, default 32: clock cycles per PDM bit, ≥2.
- `SAMPLE_STEPS`, default 256: PDM bits per audio sample, ≥2.
- `FIFO_DEPTH`, default 4: sample FIFO entries, power of two, ≥2.

Ports:
- `clk_in`, input, 1: system clock.
- `rst_in`, input, 1: reset. Asynchronous, active-low.
- `en_in`, input, 1: modulator enable.
- `audio_in`, input, 8: signed sample.
- `audio_valid_in`, input, 1: sample offered this cycle.
- `audio_ready_out`, output, 1: FIFO can accept a sample.
- `flags_clr_in`, input, 1: synchronous clear of the sticky flags.
- `pdm_out`, output, 1: registered PDM bit.
- `pdm_step_out`, output, 1: one-cycle pulse, high in the cycle `pdm_out` takes a new value.
- `fifo_count_out`, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `underrun_out`, output, 1: sticky flag; a sample boundary found the FIFO empty.
- `overflow_out`, output, 1: sticky flag; a sample was offered while the FIFO was full.

## Operation
- **Step counter** `sc`: counts 0..STEP_PERIOD-1 and wraps. An internal step is asserted when `sc == STEP_PERIOD-1` and `en_in` is high.
- **Sample counter** `wc`: advances on each step and counts 0..SAMPLE_STEPS-1. A step with `wc == SAMPLE_STEPS-1` is the sample boundary.
- **FIFO push**: occurs when `audio_valid_in && audio_ready_out`.
  - `audio_ready_out = (count != FIFO_DEPTH)`, decoded from the registered count.
  - Valid while full: the sample is dropped and `overflow_out` is set. A same-cycle pop does not free the slot for that cycle's push.
- **Pop at a sample boundary**:
  - FIFO non-empty: the head entry is loaded into the current-sample register `cur`.
  - FIFO empty: `underrun_out` is set and `cur` keeps its value.
  - A push and a boundary in the same cycle with an empty FIFO: the pop sees empty (underrun), and the pushed sample is stored for the next boundary.
- **Modulator**: runs on each step.
  - Offset conversion: `u = {~cur[7], cur[6:0]}`, range 0..255.
  - Update: `s = acc + u` (9 bits), `pdm_out <= s[8]`, `acc <= s[7:0]`.
  - Over SAMPLE_STEPS=256 steps, the ones count equals `u` exactly when `acc` starts at 0.
  - The step at a boundary uses the old `cur`. The new `cur` applies from the next step.
- **`en_in` low**:
  - `sc`, `wc` and `acc` are held at 0, `pdm_out` is 0 and `pdm_step_out` is 0.
  - FIFO contents, `cur` and the flags are retained. Pushes are still accepted.
- **`flags_clr_in`**: clears both sticky flags. A set event in the same cycle takes priority (the flag stays 1).
- **Reset values**:
  - `pdm_out`=0, `pdm_step_out`=0, `fifo_count_out`=0, `audio_ready_out`=1, both flags 0.
  - Internal: `cur`=8'sh00 (u=128), `acc`=0, `sc`=0, `wc`=0, FIFO pointers 0.

## Timing
- `pdm_out` and `pdm_step_out` are registered. Both update on the clock edge where the internal step is true, and `pdm_step_out` is high for exactly the following cycle.
- PDM bit period: STEP_PERIOD cycles. Sample window: STEP_PERIOD·SAMPLE_STEPS cycles (8192 at the defaults).
- Push to `fifo_count_out` increment: 1 cycle.
- Latency from a push into an empty FIFO to its first PDM bit: up to one window plus one step.
- First boundary after reset or enable: step index SAMPLE_STEPS-1, which is clock cycle 8191 after `en_in` rises at the defaults.
- Reset assertion mid-operation: all state clears immediately (asynchronous). Release is synchronous to `clk_in` from the next edge.

## Configuration
- `PDM_TX_UNDERRUN_MUTE_EN`:
  - Defined: an underrun boundary loads `cur` = 8'sh00 (mid-scale, 50 % density).
  - Undefined: `cur` holds its last sample.
  - `underrun_out` behaviour is identical in both cases.

## Test plan
- **Reset, idle**: reset, `en_in`=1, no pushes.
  - `pdm_out` alternates 0,1,0,1 (u=128).
  - `underrun_out` rises after the first boundary (~8192 cycles).
  - `audio_ready_out`=1 and `fifo_count_out`=0 throughout.
- **Full scale**: push 8'sh7F, wait one boundary, then count ones over the next 256 steps.
  - Exactly 255 ones.
  - Repeating with 8'sh80 gives 0 ones.
- **Overflow**: push 4 samples with no boundary in between, then offer a 5th.
  - `audio_ready_out`=0 and `fifo_count_out`=4; the 5th sample is dropped and `overflow_out`=1.
  - Later boundaries pop the 4 samples in push order.
- **Same-cycle push and pop**: push into an empty FIFO on the boundary cycle.
  - `underrun_out`=1.
  - The sample loads at the next boundary and `fifo_count_out` returns to 0.
- **Reset mid-window**: assert `rst_in` low in the middle of a window holding 2 queued samples.
  - `pdm_out`=0, `fifo_count_out`=0 and flags 0 within the same cycle, with no clock needed.
- **Underrun behaviour per build**: play 8'sh40, then let the FIFO underrun.
  - With the macro defined: the following window has 128 ones.
  - With it undefined: the following window has 192 ones.
